// File: rtl/clock_reset_sequencer.sv
// clock_reset_sequencer
//
// Purpose:
//   Master-clock-domain controller that brings the console up in lock-step
//   with the APU. The bring-up order is:
//     1. Release the APU from reset.
//     2. Wait for the APU sync pulse.
//     3. Align to an APU clock falling edge.
//     4. Switch the APU divider to the divide-by-7 cadence.
//     5. Start the CPU clock divider.
//     6. Release the CPU from reset.
//   A resync pulse in RUN re-aligns the CPU side. A missing sync ends in
//   FAULT.
//
// Ports:
//   clock_in     in   master clock (PLL global), rising edge
//   reset        in   synchronous, active-low reset
//   enable       in   level; 1 runs bring-up, 0 returns to IDLE
//   resync       in   1-cycle pulse; in RUN, re-align the CPU side
//   apusync      in   asynchronous, active-low sync from the APU
//   apuclk_fall  in   1-cycle strobe marking an APU clock falling edge
//   apu_reset_n  out  APU reset, active-low
//   doingseven   out  APU divider mode select (1 = divide-by-7)
//   cpuclk_en    out  CPU divider run enable
//   cpu_reset_n  out  CPU reset, active-low
//   locked       out  1 while in RUN
//   timeout_err  out  1 while in FAULT
//   state        out  current state code (debug/LED)
module clock_reset_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 24,
  parameter int SEVEN_DELAY  = 4,
  parameter int CPUCLK_DELAY = 4,
  parameter int CPU_RST_HOLD = 16,
  parameter int SYNC_TIMEOUT = 1000000
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       enable,
  input  logic       resync,
  input  logic       apusync,
  input  logic       apuclk_fall,
  output logic       apu_reset_n,
  output logic       doingseven,
  output logic       cpuclk_en,
  output logic       cpu_reset_n,
  output logic       locked,
  output logic       timeout_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_SEVEN = 3'd2,
    ST_CLKEN = 3'd3,
    ST_HOLD  = 3'd4,
    ST_RUN   = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] SEVEN_LAST   = CNT_W'(SEVEN_DELAY - 1);
  localparam logic [CNT_W-1:0] CPUCLK_LAST  = CNT_W'(CPUCLK_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(CPU_RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(SYNC_TIMEOUT - 1);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_prev;
  logic                   sync_fall;
  logic                   sync_latch;
  logic                   qualify;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_inc;

  // Synchronizer chain for the asynchronous apusync pin.
  // The chain and the edge-detect flop idle high, which is the pin's
  // inactive level. This means that coming out of reset never fakes a fall.
  always_ff @(posedge clock_in) begin
    if (!reset) begin
      sync_ff   <= '1;
      sync_prev <= 1'b1;
    end else begin
      sync_ff   <= {sync_ff[SYNC_STAGES-2:0], apusync};
      sync_prev <= sync_ff[SYNC_STAGES-1];
    end
  end

  assign sync_fall = sync_prev & ~sync_ff[SYNC_STAGES-1];

  // Alignment may happen in the same cycle the sync fall is seen. It does
  // not have to wait for the latch to be set first.
  assign qualify = (sync_latch | sync_fall) & apuclk_fall;

  // Shared delay/timeout counter; saturates instead of wrapping.
  assign count_inc = (count == '1) ? count : count + CNT_W'(1);

  // Bring-up state machine with registered outputs.
  // enable=0 acts like a soft reset and takes priority over everything,
  // including a resync pulse arriving in the same cycle.
  always_ff @(posedge clock_in) begin
    if (!reset || !enable) begin
      state_q     <= ST_IDLE;
      apu_reset_n <= 1'b0;
      doingseven  <= 1'b0;
      cpuclk_en   <= 1'b0;
      cpu_reset_n <= 1'b0;
      locked      <= 1'b0;
      timeout_err <= 1'b0;
      count       <= '0;
      sync_latch  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q     <= ST_ARM;
          apu_reset_n <= 1'b1;
          count       <= '0;
          sync_latch  <= 1'b0;
        end
        ST_ARM: begin
          // A qualifying alignment wins over a timeout in the same cycle.
          if (qualify) begin
            state_q    <= ST_SEVEN;
            count      <= '0;
            sync_latch <= 1'b0;
          end else if (count == TIMEOUT_LAST) begin
            state_q     <= ST_FAULT;
            timeout_err <= 1'b1;
            sync_latch  <= 1'b0;
          end else begin
            count <= count_inc;
            if (sync_fall) begin
              sync_latch <= 1'b1;
            end
          end
        end
        ST_SEVEN: begin
          if (count == SEVEN_LAST) begin
            state_q    <= ST_CLKEN;
            doingseven <= 1'b1;
            count      <= '0;
          end else begin
            count <= count_inc;
          end
        end
        ST_CLKEN: begin
          if (count == CPUCLK_LAST) begin
            state_q   <= ST_HOLD;
            cpuclk_en <= 1'b1;
            count     <= '0;
          end else begin
            count <= count_inc;
          end
        end
        ST_HOLD: begin
          if (count == HOLD_LAST) begin
            state_q     <= ST_RUN;
            cpu_reset_n <= 1'b1;
            locked      <= 1'b1;
            count       <= '0;
          end else begin
            count <= count_inc;
          end
        end
        ST_RUN: begin
          // The APU keeps running through a resync. Only the CPU side is
          // torn down and re-aligned.
          if (resync) begin
            state_q     <= ST_ARM;
            doingseven  <= 1'b0;
            cpuclk_en   <= 1'b0;
            cpu_reset_n <= 1'b0;
            locked      <= 1'b0;
            count       <= '0;
            sync_latch  <= 1'b0;
          end
        end
        ST_FAULT: begin
          apu_reset_n <= 1'b1;
          timeout_err <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          apu_reset_n <= 1'b0;
          doingseven  <= 1'b0;
          cpuclk_en   <= 1'b0;
          cpu_reset_n <= 1'b0;
          locked      <= 1'b0;
          timeout_err <= 1'b0;
          count       <= '0;
          sync_latch  <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// tb_clock_reset_sequencer
//
// Purpose:
//   Self-checking bench for clock_reset_sequencer.
//   Stimulus and expected values are given cycle by cycle. Short behaviours
//   come from a vector table. Bring-up, resync, reset and timeout sequences
//   are written out as loops.
//   The DUT is built with SYNC_TIMEOUT=100 so the timeout path is reachable.
//
// Ports: none (top-level bench).
module tb_clock_reset_sequencer;

  logic       clock_in;
  logic       reset;
  logic       enable;
  logic       resync;
  logic       apusync;
  logic       apuclk_fall;
  logic       apu_reset_n;
  logic       doingseven;
  logic       cpuclk_en;
  logic       cpu_reset_n;
  logic       locked;
  logic       timeout_err;
  logic [2:0] state;

  // Output vector order: {apu_reset_n, doingseven, cpuclk_en, cpu_reset_n, locked, timeout_err}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_ARM   = 6'b100000;
  localparam logic [5:0] O_RUN   = 6'b111110;
  localparam logic [5:0] O_FAULT = 6'b100001;

  typedef struct {
    logic       rst;
    logic       en;
    logic       rsy;
    logic       sync;
    logic       afall;
    logic [2:0] st;
    logic [5:0] outs;
    string      name;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic [5:0] outs;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   compared;
  int   mismatched;

  clock_reset_sequencer #(
    .SYNC_TIMEOUT(100)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .enable     (enable),
    .resync     (resync),
    .apusync    (apusync),
    .apuclk_fall(apuclk_fall),
    .apu_reset_n(apu_reset_n),
    .doingseven (doingseven),
    .cpuclk_en  (cpuclk_en),
    .cpu_reset_n(cpu_reset_n),
    .locked     (locked),
    .timeout_err(timeout_err),
    .state      (state)
  );

  // Free-running master clock, 10 time units per period.
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // Pop the oldest expectation and compare it against the DUT outputs.
  task automatic checkOutput();
    exp_t       e;
    logic [5:0] act;
    compared++;
    if (sb_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e   = sb_q.pop_front();
    act = {apu_reset_n, doingseven, cpuclk_en, cpu_reset_n, locked, timeout_err};
    if (state !== e.st || act !== e.outs) begin
      mismatched++;
      $display("[TB] FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
               e.name, state, act, e.st, e.outs);
    end
  endtask

  // Drive one cycle of inputs on the falling edge.
  // If checking is requested, the expectation is queued at the same time.
  // It is compared just after the rising edge that acts on those inputs.
  task automatic applyStimulus(input logic rst, input logic en, input logic rsy,
                               input logic sync, input logic afall, input bit chk,
                               input logic [2:0] st, input logic [5:0] outs,
                               input string name);
    exp_t e;
    @(negedge clock_in);
    reset       = rst;
    enable      = en;
    resync      = rsy;
    apusync     = sync;
    apuclk_fall = afall;
    if (chk) begin
      e.st   = st;
      e.outs = outs;
      e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clock_in);
    #1;
    if (chk) begin
      checkOutput();
    end
  endtask

  // Starting in ARM with apusync high, drop apusync and align.
  // With two sync stages, sync_fall is seen at the 3rd edge after the pin
  // drops.
  // mode 0: apuclk_fall arrives 2 cycles after sync_fall.
  // mode 1: apuclk_fall one cycle early (must be ignored), then again
  //         together with sync_fall (must align).
  // The run then follows alignment edge by edge until RUN.
  task automatic alignAndRun(input int mode, input string tag);
    logic [2:0] st;
    logic [5:0] outs;
    applyStimulus(1, 1, 0, 0, 0, 1, 3'd1, O_ARM, {tag, "_pin_drop"});
    applyStimulus(1, 1, 0, 0, (mode == 1), 1, 3'd1, O_ARM, {tag, "_early_afall"});
    if (mode == 1) begin
      applyStimulus(1, 1, 0, 0, 1, 1, 3'd2, O_ARM, {tag, "_same_cycle_align"});
    end else begin
      applyStimulus(1, 1, 0, 0, 0, 1, 3'd1, O_ARM, {tag, "_latched_wait"});
      applyStimulus(1, 1, 0, 0, 0, 1, 3'd1, O_ARM, {tag, "_latched_wait2"});
      applyStimulus(1, 1, 0, 0, 1, 1, 3'd2, O_ARM, {tag, "_align"});
    end
    for (int k = 1; k <= 24; k++) begin
      st   = (k < 4) ? 3'd2 : (k < 8) ? 3'd3 : (k < 24) ? 3'd4 : 3'd5;
      outs = {1'b1, (k >= 4), (k >= 8), (k >= 24), (k >= 24), 1'b0};
      applyStimulus(1, 1, 0, 0, (k % 3 == 0), 1, st, outs,
                    $sformatf("%s_seq_k%0d", tag, k));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, 1, k[0], 1, 3'd5, O_RUN, {tag, "_run_steady"});
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset       = 1'b0;
    enable      = 1'b0;
    resync      = 1'b0;
    apusync     = 1'b1;
    apuclk_fall = 1'b0;

    //          rst   en    rsy   sync  afall st    outs
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, O_IDLE, "reset_hold"};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, O_IDLE, "reset_beats_enable"};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, O_IDLE, "idle_no_enable"};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, O_ARM,  "idle_to_arm"};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, O_ARM,  "afall_no_latch_ignored"};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, O_ARM,  "resync_in_arm_ignored"};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, O_IDLE, "disable_from_arm"};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, O_ARM,  "rearm"};

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].rsy, vecs[i].sync, vecs[i].afall,
                    1, vecs[i].st, vecs[i].outs, vecs[i].name);
    end

    $display("[TB] bring-up with default delays");
    alignAndRun(0, "bringup");

    $display("[TB] resync from RUN, then full re-alignment");
    applyStimulus(1, 1, 1, 1, 0, 1, 3'd1, O_ARM, "resync_clears");
    alignAndRun(0, "resync_bringup");

    $display("[TB] early apuclk_fall ignored, same-cycle alignment");
    applyStimulus(1, 1, 1, 1, 0, 1, 3'd1, O_ARM, "resync_clears2");
    alignAndRun(1, "samecycle");

    $display("[TB] enable=0 beats resync");
    applyStimulus(1, 0, 1, 1, 0, 1, 3'd0, O_IDLE, "disable_beats_resync");
    applyStimulus(1, 1, 0, 1, 0, 1, 3'd1, O_ARM, "reenable");
    alignAndRun(0, "pre_reset");

    $display("[TB] reset mid-RUN");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 1, 0, 1, 3'd0, O_IDLE, $sformatf("reset_mid_run_%0d", i));
    end
    applyStimulus(1, 1, 0, 1, 0, 1, 3'd1, O_ARM, "reset_release");

    $display("[TB] sync timeout");
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1, 1, 0, 1, 0, 1, (i == 100) ? 3'd6 : 3'd1,
                    (i == 100) ? O_FAULT : O_ARM, $sformatf("timeout_c%0d", i));
    end
    applyStimulus(1, 1, 1, 0, 1, 1, 3'd6, O_FAULT, "fault_ignores_resync");
    applyStimulus(1, 1, 0, 0, 1, 1, 3'd6, O_FAULT, "fault_ignores_sync");
    applyStimulus(1, 1, 0, 0, 1, 1, 3'd6, O_FAULT, "fault_ignores_afall");
    applyStimulus(1, 0, 0, 1, 0, 1, 3'd0, O_IDLE, "fault_exit_disable");

    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
